// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, req/gnt/rvalid memory handshake, and a {PC, INSTR} buffer toward decode.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        IF_VALID,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTR,
  input  logic        IF_READY
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] PERF_FETCHED,
  output logic [31:0] PERF_STALL
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_pc_nxt;
  logic [31:0]   r_req_pc;
  logic          r_drop;
  logic          w_drop_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_mem_pc    [FIFO_DEPTH];
  logic [31:0]   r_mem_instr [FIFO_DEPTH];

  logic w_gnt;
  logic w_rsp;
  logic w_push;
  logic w_pop;
  logic w_space;
  logic w_unused;

  assign w_unused = ^REDIRECT_PC[1:0];

  assign IMEM_REQ  = (r_state == S_REQ);
  assign IMEM_ADDR = r_fetch_pc;
  assign IF_VALID  = (r_count != '0);
  assign IF_PC     = r_mem_pc[r_rd_ptr];
  assign IF_INSTR  = r_mem_instr[r_rd_ptr];

  // WAIT is the only state with a request in flight, so a response is only honoured there.
  assign w_gnt  = (r_state == S_REQ) && IMEM_GNT;
  assign w_rsp  = (r_state == S_WAIT) && IMEM_RVALID;
  assign w_push = w_rsp && !r_drop && !REDIRECT;
  assign w_pop  = IF_VALID && IF_READY && !REDIRECT;

  always_comb begin
    w_count_nxt = r_count;
    if (REDIRECT) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Space is judged on post-update occupancy with nothing outstanding, which gives the 2-cycle fetch loop.
  assign w_space = (w_count_nxt < DEPTH_C);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_fetch_pc;
    w_drop_nxt  = r_drop;
    case (r_state)
      S_IDLE: begin
        if (w_space) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_gnt) begin
          w_pc_nxt    = r_fetch_pc + 32'd4;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_rsp) begin
          w_drop_nxt  = 1'b0;
          w_state_nxt = w_space ? S_REQ : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A response landing in the redirect cycle is already consumed, so it needs no drop.
    if (REDIRECT) begin
      w_pc_nxt = {REDIRECT_PC[31:2], 2'b00};
      if (w_gnt || ((r_state == S_WAIT) && !IMEM_RVALID)) begin
        w_drop_nxt  = 1'b1;
        w_state_nxt = S_WAIT;
      end else begin
        w_drop_nxt  = 1'b0;
        w_state_nxt = S_REQ;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= {RESET_PC[31:2], 2'b00};
      r_req_pc   <= '0;
      r_drop     <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_count    <= w_count_nxt;
      if (w_gnt) r_req_pc <= r_fetch_pc;
      if (REDIRECT) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_req_pc;
      r_mem_instr[r_wr_ptr] <= IMEM_RDATA;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_push) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (!IF_VALID && IF_READY) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign PERF_FETCHED = r_perf_fetched;
  assign PERF_STALL   = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: inputs driven and outputs sampled 1ns after each rising edge.
module tb_if_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        IF_VALID;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
  logic        IF_READY;
`ifdef FETCH_PERF_EN
  logic [31:0] PERF_FETCHED;
  logic [31:0] PERF_STALL;
`endif

  int n_chk = 0;
  int n_err = 0;

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REDIRECT   (REDIRECT),
    .REDIRECT_PC(REDIRECT_PC),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_GNT   (IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID),
    .IMEM_RDATA (IMEM_RDATA),
    .IF_VALID   (IF_VALID),
    .IF_PC      (IF_PC),
    .IF_INSTR   (IF_INSTR),
    .IF_READY   (IF_READY)
`ifdef FETCH_PERF_EN
    ,
    .PERF_FETCHED(PERF_FETCHED),
    .PERF_STALL  (PERF_STALL)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_chk++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reset, then release; the unit leaves IDLE for REQ one cycle after release.
  task automatic do_reset();
    RST_N = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0; IF_READY = 1'b0;
    tick();
    chk("rst_req", {31'b0, IMEM_REQ}, 32'd0);
    chk("rst_valid", {31'b0, IF_VALID}, 32'd0);
    chk("rst_addr", IMEM_ADDR, 32'h0);
    RST_N = 1'b1;
    tick();
    chk("rst_to_req", {31'b0, IMEM_REQ}, 32'd1);
  endtask

  // From REQ with GNT=1 and IF_READY=1: grant, 1-cycle response, head becomes this fetch.
  task automatic fetch_one(input logic [31:0] pc);
    chk("f_req", {31'b0, IMEM_REQ}, 32'd1);
    chk("f_addr", IMEM_ADDR, pc);
    tick();
    chk("f_wait_req", {31'b0, IMEM_REQ}, 32'd0);
    chk("f_wait_valid", {31'b0, IF_VALID}, 32'd0);
    IMEM_RVALID = 1'b1; IMEM_RDATA = ~pc;
    tick();
    IMEM_RVALID = 1'b0;
    chk("f_valid", {31'b0, IF_VALID}, 32'd1);
    chk("f_pc", IF_PC, pc);
    chk("f_instr", IF_INSTR, ~pc);
  endtask

  initial begin
    // 1: streaming fetch
    do_reset();
    IMEM_GNT = 1'b1; IF_READY = 1'b1;
    fetch_one(32'h0);
    fetch_one(32'h4);
    fetch_one(32'h8);
    chk("t1_next_addr", IMEM_ADDR, 32'hC);

    // reset while a request is outstanding; a late response is ignored
    tick();
    chk("t1r_wait", {31'b0, IMEM_REQ}, 32'd0);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1; IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF;
    tick();
    IMEM_RVALID = 1'b0;
    chk("t1r_valid", {31'b0, IF_VALID}, 32'd0);
    chk("t1r_req", {31'b0, IMEM_REQ}, 32'd1);
    chk("t1r_addr", IMEM_ADDR, 32'h0);

    // 2: decode stalled, fill to depth then stop requesting
    do_reset();
    IMEM_GNT = 1'b1; IF_READY = 1'b0;
    tick();
    IMEM_RVALID = 1'b1; IMEM_RDATA = ~32'h0;
    tick();
    IMEM_RVALID = 1'b0;
    chk("t2_addr4", IMEM_ADDR, 32'h4);
    tick();
    IMEM_RVALID = 1'b1; IMEM_RDATA = ~32'h4;
    tick();
    IMEM_RVALID = 1'b0;
    chk("t2_full_head", IF_PC, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_idle_req", {31'b0, IMEM_REQ}, 32'd0);
      tick();
    end
    IF_READY = 1'b1;
    tick();
    chk("t2_resume_req", {31'b0, IMEM_REQ}, 32'd1);
    chk("t2_resume_addr", IMEM_ADDR, 32'h8);
    chk("t2_head4", IF_PC, 32'h4);
    chk("t2_instr4", IF_INSTR, ~32'h4);

    // 3: redirect with a fetch of 0x8 outstanding and an entry buffered
    do_reset();
    IMEM_GNT = 1'b1; IF_READY = 1'b1;
    fetch_one(32'h0);
    fetch_one(32'h4);
    IF_READY = 1'b0;
    tick();
    chk("t3_held", IF_PC, 32'h4);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h100;
    tick();
    REDIRECT = 1'b0;
    chk("t3_flush", {31'b0, IF_VALID}, 32'd0);
    chk("t3_waitdrop", {31'b0, IMEM_REQ}, 32'd0);
    chk("t3_addr", IMEM_ADDR, 32'h100);
    IMEM_RVALID = 1'b1; IMEM_RDATA = ~32'h8;
    tick();
    IMEM_RVALID = 1'b0;
    chk("t3_dropped", {31'b0, IF_VALID}, 32'd0);
    IF_READY = 1'b1;
    fetch_one(32'h100);

    // 4: unaligned redirect at grant, then redirect coinciding with response and pop
    do_reset();
    IMEM_GNT = 1'b1; IF_READY = 1'b1;
    REDIRECT = 1'b1; REDIRECT_PC = 32'h203;
    tick();
    REDIRECT = 1'b0;
    chk("t4_align", IMEM_ADDR, 32'h200);
    chk("t4_wait", {31'b0, IMEM_REQ}, 32'd0);
    IMEM_RVALID = 1'b1; IMEM_RDATA = ~32'h0;
    tick();
    IMEM_RVALID = 1'b0;
    chk("t4_drop0", {31'b0, IF_VALID}, 32'd0);
    fetch_one(32'h200);
    IF_READY = 1'b0;
    tick();
    chk("t4_head", IF_PC, 32'h200);
    IF_READY = 1'b1; IMEM_RVALID = 1'b1; IMEM_RDATA = ~32'h204;
    REDIRECT = 1'b1; REDIRECT_PC = 32'h300;
    tick();
    REDIRECT = 1'b0; IMEM_RVALID = 1'b0;
    chk("t4_empty", {31'b0, IF_VALID}, 32'd0);
    fetch_one(32'h300);

    // 5: grant withheld; stray RVALID in REQ ignored
    IMEM_GNT = 1'b0; IF_READY = 1'b0; IMEM_RVALID = 1'b1; IMEM_RDATA = 32'h1234_5678;
    tick();
    IMEM_RVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_req", {31'b0, IMEM_REQ}, 32'd1);
      chk("t5_addr", IMEM_ADDR, 32'h304);
      chk("t5_head", IF_PC, 32'h300);
      tick();
    end
    IMEM_GNT = 1'b1; IF_READY = 1'b1;
    fetch_one(32'h304);

    // address wrap
    IMEM_GNT = 1'b0; REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFC;
    tick();
    REDIRECT = 1'b0; IMEM_GNT = 1'b1;
    fetch_one(32'hFFFF_FFFC);
    chk("wrap_addr", IMEM_ADDR, 32'h0);

`ifdef FETCH_PERF_EN
    // 6: three pushes, two starved cycles
    do_reset();
    chk("p_rst_f", PERF_FETCHED, 32'd0);
    chk("p_rst_s", PERF_STALL, 32'd0);
    IMEM_GNT = 1'b1; IF_READY = 1'b0;
    tick();
    IMEM_RVALID = 1'b1; IMEM_RDATA = ~32'h0;
    tick();
    IMEM_RVALID = 1'b0;
    tick();
    IMEM_RVALID = 1'b1; IMEM_RDATA = ~32'h4;
    tick();
    IMEM_RVALID = 1'b0; IF_READY = 1'b1;
    tick();
    tick();
    IMEM_RVALID = 1'b1; IMEM_RDATA = ~32'h8;
    tick();
    IMEM_RVALID = 1'b0;
    tick();
    tick();
    IF_READY = 1'b0;
    tick();
    chk("p_fetched", PERF_FETCHED, 32'd3);
    chk("p_stall", PERF_STALL, 32'd2);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    chk("p_clr_f", PERF_FETCHED, 32'd0);
    chk("p_clr_s", PERF_STALL, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
